// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing 16-bit words into the instruction ROM
// Holds the CPU in reset while loading; validates the image with a length header and XOR checksum.
module prog_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_len;
  logic [16:0]           r_cnt;
  logic [7:0]            r_hi;
  logic [7:0]            r_chk;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [15:0]           r_mem_wdata;

  logic [15:0]           w_len;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_start;

  assign w_len    = {r_len_hi, in_byte};
  assign w_last   = ((r_cnt + 17'd1) == {1'b0, r_len});
  assign in_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                    (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                    (r_state == S_CHECK);
  assign w_accept = in_valid && in_ready;
  assign w_start  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                              (r_state == S_ERROR));

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Flags follow the state register, so they settle one cycle after the deciding byte.
  always_comb begin
    w_next   = r_state;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (in_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (in_valid) begin
          if ({1'b0, w_len} > MAX_WORDS) begin
            w_next = S_ERROR;
          end else if (w_len == 16'd0) begin
            w_next = S_CHECK;
          end else begin
            w_next = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (in_valid) w_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (in_valid) w_next = w_last ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: begin
        if (in_valid) w_next = (in_byte == r_chk) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) w_next = S_LEN_HI;
      end
      S_ERROR: begin
        done  = 1'b1;
        error = 1'b1;
        if (start) w_next = S_LEN_HI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Reset has priority, which also drops a write strobe decided on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_hi    <= 8'd0;
      r_len       <= 16'd0;
      r_cnt       <= 17'd0;
      r_hi        <= 8'd0;
      r_chk       <= 8'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'd0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start) begin
        r_cnt <= 17'd0;
        r_chk <= 8'd0;
      end
      if (w_accept) begin
        case (r_state)
          S_LEN_HI: r_len_hi <= in_byte;
          S_LEN_LO: r_len    <= w_len;
          S_DATA_HI: begin
            r_hi  <= in_byte;
            r_chk <= r_chk ^ in_byte;
          end
          S_DATA_LO: begin
            r_chk       <= r_chk ^ in_byte;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_cnt[ADDR_WIDTH-1:0];
            r_mem_wdata <= {r_hi, in_byte};
            r_cnt       <= r_cnt + 17'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
// Expected ROM writes and flags come from parsing each byte stream directly.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int we_double = 0;
  logic prev_we = 1'b0;

  logic [7:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_cyc[$];

  prog_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we && prev_we) we_double++;
    prev_we = mem_we;
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    we_double = 0;
  endtask

  // Called on a negedge; start is seen by exactly one rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers bytes with in_valid asserted pct% of cycles; returns on the negedge after the last accept.
  task automatic send(input logic [7:0] s[$], input int pct);
    logic [7:0] q[$];
    bit acc;
    int budget;
    q = s;
    budget = 0;
    while (q.size() > 0) begin
      in_valid = ($urandom_range(0, 99) < pct);
      in_byte  = in_valid ? q[0] : 8'($urandom);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) void'(q.pop_front());
      @(negedge clk);
      budget++;
      if (budget > 5000) begin
        check("send_timeout", 32'(q.size()), 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic make_image(input int n, input bit corrupt, output logic [7:0] s[$]);
    logic [7:0] b;
    logic [7:0] x;
    s.delete();
    x = 8'd0;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      s.push_back(b);
    end
    s.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
  endtask

  // Parses the stream as the loader should and compares flags and the write log.
  task automatic check_result(input logic [7:0] s[$], input bit exact_spacing);
    int n;
    int nw;
    bit exp_err;
    logic [7:0] x;
    n = {s[0], s[1]};
    x = 8'd0;
    if (n > 256) begin
      exp_err = 1'b1;
      nw = 0;
    end else begin
      nw = n;
      for (int i = 2; i < 2 + 2 * n; i++) x = x ^ s[i];
      exp_err = (s[2 + 2 * n] != x);
    end
    check("done", done, 1);
    check("error", error, exp_err);
    check("cpu_hold", cpu_hold, exp_err);
    check("in_ready_end", in_ready, 0);
    repeat (2) @(negedge clk);
    check("write_count", wr_addr.size(), nw);
    for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
      check("wr_addr", wr_addr[i], 32'(i[7:0]));
      check("wr_data", wr_data[i], {s[2 + 2 * i], s[3 + 2 * i]});
      if (i > 0) begin
        if (exact_spacing) check("wr_spacing", wr_cyc[i] - wr_cyc[i - 1], 2);
        else check("wr_spacing_min", (wr_cyc[i] - wr_cyc[i - 1]) >= 2, 1);
      end
    end
    check("we_one_cycle", we_double, 0);
  endtask

  task automatic run_load(input logic [7:0] s[$], input int pct, input bit exact_spacing);
    clear_log();
    pulse_start();
    send(s, pct);
    check_result(s, exact_spacing);
  endtask

  logic [7:0] basic[$];
  logic [7:0] bad[$];
  logic [7:0] img[$];

  initial begin
    basic = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    bad   = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Bytes offered while idle must not be taken.
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    run_load(basic, 100, 1'b1);
    check("basic_rom0", wr_data.size() > 0 ? wr_data[0] : 16'hxxxx, 16'h1234);
    check("basic_rom1", wr_data.size() > 1 ? wr_data[1] : 16'hxxxx, 16'hABCD);

    run_load(bad, 100, 1'b1);

    img = '{8'h00, 8'h00, 8'h00};
    run_load(img, 100, 1'b1);

    img = '{8'h01, 8'h01};
    run_load(img, 100, 1'b1);

    make_image(256, 1'b0, img);
    run_load(img, 100, 1'b1);
    check("n256_last_addr", wr_addr.size() == 256 ? wr_addr[255] : 8'h00, 8'hFF);

    run_load(basic, 40, 1'b0);

    for (int t = 0; t < 6; t++) begin
      make_image($urandom_range(1, 12), ($urandom_range(0, 2) == 0), img);
      run_load(img, $urandom_range(30, 95), 1'b0);
    end

    // start pulsed mid-load is ignored and the image still lands intact.
    clear_log();
    pulse_start();
    img = '{8'h00, 8'h02, 8'h12};
    send(img, 100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    img = '{8'h34, 8'hAB, 8'hCD, 8'h40};
    send(img, 100);
    check_result(basic, 1'b0);

    // Reset right after the first word: no further writes, CPU stays held.
    clear_log();
    pulse_start();
    img = '{8'h00, 8'h02, 8'h12, 8'h34};
    send(img, 100);
    rst = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'hAB;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_state_ready", in_ready, 0);
    check("rst_mid_cpu_hold", cpu_hold, 1);
    check("rst_mid_done", done, 0);
    check("rst_mid_error", error, 0);
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid_writes", wr_addr.size(), 1);

    // Reset on the same edge as the DATA_LO accept suppresses that write.
    clear_log();
    pulse_start();
    img = '{8'h00, 8'h02, 8'h12};
    send(img, 100);
    rst = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'h34;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_suppress_we", mem_we, 0);
    repeat (2) @(negedge clk);
    check("rst_suppress_writes", wr_addr.size(), 0);
    check("rst_suppress_hold", cpu_hold, 1);

    run_load(basic, 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
